// File: rtl/dual_port_ram_master_pkg.sv
// Shared constants for dual_port_ram_master: FSM encodings, in-flight pipe depth
// and the width helper for occupancy counters.
package dual_port_ram_master_pkg;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  localparam int unsigned INFLIGHT_STAGES = 2;

  // Bits needed to hold a count from 0 to depth inclusive
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dual_port_ram.sv
// Two-port synchronous RAM with a one-cycle registered read on each port.
// Port 2 wins when both ports write the same address in the same cycle.
module dual_port_ram #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] data1,
  output logic [DATA_WIDTH-1:0] out1,
  input  logic                  we2,
  input  logic [ADDR_WIDTH-1:0] addr2,
  input  logic [DATA_WIDTH-1:0] data2,
  output logic [DATA_WIDTH-1:0] out2
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Writes and registered reads for both ports
  always_ff @(posedge clk) begin
    if (we1) mem[addr1] <= data1;
    if (we2) mem[addr2] <= data2;
    out1 <= mem[addr1];
    out2 <= mem[addr2];
  end

endmodule

// File: rtl/dual_port_ram_master_rsp_fifo.sv
// First-word-fall-through response buffer for dual_port_ram_master.
// The caller guarantees no push when full and no pop when empty.
module dual_port_ram_master_rsp_fifo
  import dual_port_ram_master_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  // Pointer advance with explicit wrap so non-power-of-two depths work
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Storage, pointers and occupancy; storage cleared so the head reads zero after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_i) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign valid_o = (count_q != '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/dual_port_ram_master.sv
// Command/response initiator for one port of dual_port_ram.
// Define DPRM_BURST_EN to add the cmd_len port and multi-beat bursts.
module dual_port_ram_master
  import dual_port_ram_master_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned RSP_DEPTH  = 2
`ifdef DPRM_BURST_EN
  , parameter int unsigned LEN_WIDTH = 4
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
`ifdef DPRM_BURST_EN
  input  logic [LEN_WIDTH-1:0]  cmd_len,
`endif
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam int unsigned CNT_W = cnt_width(RSP_DEPTH);
  localparam int unsigned OCC_W = CNT_W + 1;

  logic [CNT_W-1:0]           buf_count;
  logic [OCC_W-1:0]           occ_c;
  logic                       credit_c;
  logic                       rd_issue_c;
  logic                       pop_c;
  logic [INFLIGHT_STAGES-1:0] infl_q, infl_d;
  logic                       ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0]      ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0]      ram_wdata_q, ram_wdata_d;
`ifdef DPRM_BURST_EN
  logic [0:0]                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]      beat_addr_q, beat_addr_d;
  logic [LEN_WIDTH-1:0]       beats_left_q, beats_left_d;
  logic                       burst_we_q, burst_we_d;
  logic [DATA_WIDTH-1:0]      burst_wdata_q, burst_wdata_d;
`endif

  // Credit: buffered responses plus reads still travelling through the RAM
  assign occ_c    = OCC_W'(buf_count) + OCC_W'($countones(infl_q));
  assign credit_c = (occ_c < OCC_W'(RSP_DEPTH));
  assign pop_c    = rsp_valid && rsp_ready;
  assign infl_d   = {infl_q[INFLIGHT_STAGES-2:0], rd_issue_c};

  // Command acceptance, beat sequencing and next RAM port values
  always_comb begin
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    rd_issue_c  = 1'b0;
    cmd_ready   = 1'b0;
`ifdef DPRM_BURST_EN
    state_d       = state_q;
    beat_addr_d   = beat_addr_q;
    beats_left_d  = beats_left_q;
    burst_we_d    = burst_we_q;
    burst_wdata_d = burst_wdata_q;
    case (state_q)
      IDLE: begin
        cmd_ready = cmd_we || credit_c;
        if (cmd_valid && cmd_ready) begin
          ram_we_d    = cmd_we;
          ram_addr_d  = cmd_addr;
          ram_wdata_d = cmd_wdata;
          rd_issue_c  = !cmd_we;
          if (cmd_len != '0) begin
            state_d       = BURST;
            beat_addr_d   = cmd_addr + ADDR_WIDTH'(1);
            beats_left_d  = cmd_len;
            burst_we_d    = cmd_we;
            burst_wdata_d = cmd_wdata;
          end
        end
      end
      BURST: begin
        // A read beat without credit waits; beats are never skipped
        if (burst_we_q || credit_c) begin
          ram_we_d     = burst_we_q;
          ram_addr_d   = beat_addr_q;
          ram_wdata_d  = burst_wdata_q;
          rd_issue_c   = !burst_we_q;
          beat_addr_d  = beat_addr_q + ADDR_WIDTH'(1);
          beats_left_d = beats_left_q - LEN_WIDTH'(1);
          if (beats_left_q == LEN_WIDTH'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
`else
    cmd_ready = cmd_we || credit_c;
    if (cmd_valid && cmd_ready) begin
      ram_we_d    = cmd_we;
      ram_addr_d  = cmd_addr;
      ram_wdata_d = cmd_wdata;
      rd_issue_c  = !cmd_we;
    end
`endif
  end

  // RAM port registers, in-flight pipe and burst context
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_we_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
      infl_q        <= '0;
`ifdef DPRM_BURST_EN
      state_q       <= IDLE;
      beat_addr_q   <= '0;
      beats_left_q  <= '0;
      burst_we_q    <= 1'b0;
      burst_wdata_q <= '0;
`endif
    end else begin
      ram_we_q      <= ram_we_d;
      ram_addr_q    <= ram_addr_d;
      ram_wdata_q   <= ram_wdata_d;
      infl_q        <= infl_d;
`ifdef DPRM_BURST_EN
      state_q       <= state_d;
      beat_addr_q   <= beat_addr_d;
      beats_left_q  <= beats_left_d;
      burst_we_q    <= burst_we_d;
      burst_wdata_q <= burst_wdata_d;
`endif
    end
  end

  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

  dual_port_ram_master_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DATA_WIDTH),
    .CNT_W (CNT_W)
  ) u_rsp_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (infl_q[INFLIGHT_STAGES-1]),
    .push_data_i (ram_rdata),
    .pop_i       (pop_c),
    .valid_o     (rsp_valid),
    .head_o      (rsp_data),
    .count_o     (buf_count)
  );

endmodule
